pc_stall_unit: RTL

- Parametrised program-counter unit for the single-cycle/stall MIPS core. It sits in front of instruction memory.
- Generates the fetch address each cycle. Inserts a configurable number of hold cycles when a load is detected in decode.
- Adds branch and jump redirect and an external hold input, generalising the fixed 8-bit, one-bubble PC logic.

---
 rtl/pc_stall_unit_if.sv | 43 ++++
 rtl/pc_stall_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/pc_stall_unit_if.sv
// rtl/pc_stall_unit_if.sv - decode/fetch handshake bundle between the core and the PC unit
interface pc_stall_unit_if #(
    parameter int PC_W = 8
);
    // decode-stage request side
    logic            mem_read;
    logic            hold;
    logic            branch_taken;
    logic [31:0]     branch_offset;
    logic            jump;
    logic [PC_W-1:0] jump_target;

    // fetch side
    logic [PC_W-1:0] pc;
    logic            stall;
    logic            flush;

    // core / pipeline control drives requests and observes the fetch address
    modport master (
        output mem_read,
        output hold,
        output branch_taken,
        output branch_offset,
        output jump,
        output jump_target,
        input  pc,
        input  stall,
        input  flush
    );

    // PC unit consumes requests and produces the fetch address
    modport slave (
        input  mem_read,
        input  hold,
        input  branch_taken,
        input  branch_offset,
        input  jump,
        input  jump_target,
        output pc,
        output stall,
        output flush
    );
endinterface

// File: rtl/pc_stall_unit.sv
// rtl/pc_stall_unit.sv - program counter with load-use hold, branch/jump redirect and external freeze
module pc_stall_unit #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_BYTES = 4,
    parameter int              LOAD_STALL  = 1,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_stall_unit_if.slave    bus
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_LSTALL = 1'b1;

    localparam logic [PC_W-1:0] PC_INC        = PC_W'(INSTR_BYTES);
    localparam bit              LOAD_STALL_EN = (LOAD_STALL > 0);
    // The edge that accepts the load already holds the PC, so the counter
    // only has to cover the remaining LOAD_STALL-1 hold edges.
    localparam logic [3:0]      CNT_INIT      = LOAD_STALL_EN ? 4'(LOAD_STALL - 1) : 4'd0;

    logic [0:0]      state_q;
    logic [0:0]      state_nxt;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_nxt;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;

    logic [PC_W+33:0] offset_ext;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_branch;
    logic [PC_W-1:0]  pc_jump;
    logic             redirect;

    // Word offset scaled to bytes and sign-extended past PC_W so any PC width
    // takes its low bits with correct two's-complement wrap.
    assign offset_ext = {{PC_W{bus.branch_offset[31]}}, bus.branch_offset, 2'b00};
    assign pc_seq     = pc_q + PC_INC;
    assign pc_branch  = pc_seq + offset_ext[PC_W-1:0];
    // Jump targets are forced onto a word boundary.
    assign pc_jump    = {bus.jump_target[PC_W-1:2], 2'b00};

    // A redirect only counts when the unit is not frozen.
    assign redirect = !bus.hold && (bus.jump || bus.branch_taken);

    logic unused_bits;
    assign unused_bits = ^{offset_ext[PC_W+33:PC_W], bus.jump_target[1:0]};

    // Next-state selection: hold > jump > branch > load stall > sequential.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pc_nxt    = pc_q;
        if (bus.hold) begin
            state_nxt = state_q;
        end else if (bus.jump) begin
            pc_nxt    = pc_jump;
            state_nxt = S_RUN;
            cnt_nxt   = 4'd0;
        end else if (bus.branch_taken) begin
            pc_nxt    = pc_branch;
            state_nxt = S_RUN;
            cnt_nxt   = 4'd0;
        end else if (state_q == S_LSTALL) begin
            // mem_read is deliberately ignored here so the stalled load
            // cannot re-arm the hold.
            if (cnt_q == 4'd0) begin
                pc_nxt    = pc_seq;
                state_nxt = S_RUN;
            end else begin
                cnt_nxt = cnt_q - 4'd1;
            end
        end else if (LOAD_STALL_EN && bus.mem_read) begin
            state_nxt = S_LSTALL;
            cnt_nxt   = CNT_INIT;
        end else begin
            pc_nxt = pc_seq;
        end
    end

    // PC, state and hold counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= S_RUN;
            cnt_q   <= 4'd0;
        end else begin
            pc_q    <= pc_nxt;
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.stall = (state_q == S_LSTALL);
    // Flush is suppressed while reset is asserted so nothing downstream is
    // killed by a redirect request that will never be taken.
    assign bus.flush = rst_n && redirect;

endmodule
